// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Inter-stage pipeline buffer. Carries an opaque payload between two stages
//   with a valid/allow_in handshake, a synchronous flush (branch cancel) and
//   DEPTH-entry storage. DEPTH=1 behaves as a plain stage register whose
//   allow_in passes through combinationally from downstream. DEPTH>=2 is a
//   skid FIFO whose allow_in depends only on registered occupancy.
//
//   dn_data is always entry[rd_ptr], whether or not dn_valid is set. There is
//   no bypass path: a push at edge N is first visible on dn_data after edge N.

module pipe_stage_buf #(
  parameter int                DATA_W  = 160,
  parameter int                DEPTH   = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       resetn,
  // upstream side
  input  logic                       up_valid,
  input  logic [DATA_W-1:0]          up_data,
  output logic                       up_allow_in,
  // branch cancel
  input  logic                       flush,
  // owning stage
  input  logic                       stage_ready_go,
  // downstream side
  output logic                       dn_valid,
  output logic [DATA_W-1:0]          dn_data,
  input  logic                       dn_allow_in,
  // occupancy
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // A one-entry buffer still needs a 1-bit pointer so the port and index
  // declarations stay legal; the pointer simply never leaves 0.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Reject illegal depths at elaboration rather than build a broken buffer.
  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("pipe_stage_buf: DEPTH must be in the range 1..4");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic not_empty;
  logic push;
  logic pop;

  // Pointers wrap at DEPTH-1 explicitly, so a non-power-of-two DEPTH such as 3
  // never walks onto an entry that does not exist.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign not_empty = (count_q != '0);

  // The owning stage can hold its head entry by lowering stage_ready_go.
  assign dn_valid  = not_empty & stage_ready_go;
  assign pop       = dn_valid & dn_allow_in;

  // A cancelled instruction must never enter the buffer.
  assign push      = up_valid & up_allow_in & ~flush;

  generate
    if (DEPTH == 1) begin : g_stage_reg
      // Single register: accept when empty, or when the held entry leaves in
      // this same cycle so the new one can replace it.
      assign up_allow_in = ~not_empty | (stage_ready_go & dn_allow_in);
    end else begin : g_skid
      // Skid FIFO: allow_in comes only from registered occupancy, which breaks
      // the combinational path from dn_allow_in back to the upstream stage.
      assign up_allow_in = (count_q < CNT_FULL);
    end
  endgenerate

  assign dn_data = entry_q[rd_ptr_q];
  assign count   = count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Pointer and occupancy update; flush wins over both push and pop.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop cancel, leaving the occupancy unchanged.
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Control state: pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from before the edge, regardless of order.
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; flush leaves contents alone, only a push overwrites.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the entries are reset on purpose: dn_data is visible while empty,
    // so after reset it must read RST_VAL (e.g. the boot pc) and not X. This
    // keeps the storage in flops rather than a RAM macro, which is fine at
    // DEPTH <= 4.
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= RST_VAL;
      end
    end else if (push) begin
      entry_q[wr_ptr_q] <= up_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // Occupancy never exceeds the number of entries.
  a_count_in_range : assert property (
    @(posedge clk) disable iff (!resetn) count_q <= CNT_FULL
  );

  // A push into a full buffer is only legal when the head leaves in the same
  // cycle (one-entry register replacement).
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!resetn) push |-> ((count_q < CNT_FULL) || pop)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
//   Drives three buffers (DEPTH = 1, 2, 3) from one shared set of inputs. A
//   list-based reference model per buffer predicts the handshake outputs,
//   occupancy and head payload. Directed scenarios use hand-derived constants.

module tb_pipe_stage_buf;

  localparam int             DW = 32;
  localparam logic [DW-1:0]  RV = 32'h1c00_0000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          up_valid;
  logic [DW-1:0] up_data;
  logic          flush;
  logic          stage_ready_go;
  logic          dn_allow_in;

  logic          al [3];
  logic          dv [3];
  logic [DW-1:0] dd [3];
  logic [0:0]    c1;
  logic [1:0]    c2;
  logic [1:0]    c3;

  int unsigned   n_cmp  = 0;
  int unsigned   n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(1), .RST_VAL(RV)) u_d1 (
    .clk(clk), .resetn(resetn), .up_valid(up_valid), .up_data(up_data),
    .up_allow_in(al[0]), .flush(flush), .stage_ready_go(stage_ready_go),
    .dn_valid(dv[0]), .dn_data(dd[0]), .dn_allow_in(dn_allow_in), .count(c1)
  );

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .RST_VAL(RV)) u_d2 (
    .clk(clk), .resetn(resetn), .up_valid(up_valid), .up_data(up_data),
    .up_allow_in(al[1]), .flush(flush), .stage_ready_go(stage_ready_go),
    .dn_valid(dv[1]), .dn_data(dd[1]), .dn_allow_in(dn_allow_in), .count(c2)
  );

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(3), .RST_VAL(RV)) u_d3 (
    .clk(clk), .resetn(resetn), .up_valid(up_valid), .up_data(up_data),
    .up_allow_in(al[2]), .flush(flush), .stage_ready_go(stage_ready_go),
    .dn_valid(dv[2]), .dn_data(dd[2]), .dn_allow_in(dn_allow_in), .count(c3)
  );

  // ---------------------------------------------------------------------------
  // Reference model: an ordered list per buffer (element 0 is the head).
  // ---------------------------------------------------------------------------
  int            m_cnt  [3];
  logic [DW-1:0] m_list [3][4];
  logic [DW-1:0] m_last1;   // what the one-entry buffer shows while empty

  function automatic int depth_of(input int k);
    return k + 1;
  endfunction

  function automatic logic [2:0] dut_count(input int k);
    case (k)
      0:       return {2'b00, c1};
      1:       return {1'b0, c2};
      default: return {1'b0, c3};
    endcase
  endfunction

  function automatic logic exp_dv(input int k);
    return (m_cnt[k] != 0) && stage_ready_go;
  endfunction

  function automatic logic exp_allow(input int k);
    if (depth_of(k) == 1) return (m_cnt[k] == 0) || (stage_ready_go && dn_allow_in);
    return m_cnt[k] < depth_of(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_last1 = RV;
  endtask

  // Applies one clock edge to the model using the inputs present at the edge.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic do_push;
      logic do_pop;
      do_push = up_valid && exp_allow(k) && !flush;
      do_pop  = exp_dv(k) && dn_allow_in;
      if (flush) begin
        m_cnt[k] = 0;
      end else begin
        if (do_pop) begin
          for (int j = 0; j < 3; j++) m_list[k][j] = m_list[k][j+1];
          m_cnt[k]--;
        end
        if (do_push) begin
          m_list[k][m_cnt[k]] = up_data;
          m_cnt[k]++;
          if (k == 0) m_last1 = up_data;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    up_valid       = 1'b0;
    up_data        = '0;
    flush          = 1'b0;
    stage_ready_go = 1'b1;
    dn_allow_in    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #3;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (dut_count(k) !== 3'd0) begin n_fail++; $display("FAIL reset_in_count[%0d]: got %0d want 0", k, dut_count(k)); end
      n_cmp++; if (dv[k] !== 1'b0) begin n_fail++; $display("FAIL reset_in_dn_valid[%0d]: got %b want 0", k, dv[k]); end
      n_cmp++; if (dd[k] !== RV) begin n_fail++; $display("FAIL reset_in_dn_data[%0d]: got %h want %h", k, dd[k], RV); end
      n_cmp++; if (al[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_allow[%0d]: got %b want 1", k, al[k]); end
    end
    do_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (dut_count(k) !== 3'd0) begin n_fail++; $display("FAIL reset_out_count[%0d]: got %0d want 0", k, dut_count(k)); end
      n_cmp++; if (dv[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_dn_valid[%0d]: got %b want 0", k, dv[k]); end
      n_cmp++; if (dd[k] !== RV) begin n_fail++; $display("FAIL reset_out_dn_data[%0d]: got %h want %h", k, dd[k], RV); end
      n_cmp++; if (al[k] !== 1'b1) begin n_fail++; $display("FAIL reset_out_allow[%0d]: got %b want 1", k, al[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [3];
    vals[0] = 32'h0000_000A;
    vals[1] = 32'h0000_000B;
    vals[2] = 32'h0000_000C;
    do_reset();
    stage_ready_go = 1'b1;
    dn_allow_in    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_valid = (i < 3);
      up_data  = (i < 3) ? vals[i] : '0;
      #2;
      n_cmp++; if (al[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_allow cycle %0d: got %b want 1", i, al[0]); end
      if (i > 0) begin
        n_cmp++; if (dv[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_dn_valid cycle %0d: got %b want 1", i, dv[0]); end
        n_cmp++; if (dd[0] !== vals[i-1]) begin n_fail++; $display("FAIL b2b_dn_data cycle %0d: got %h want %h", i, dd[0], vals[i-1]); end
      end
      tick();
    end
    #2;
    n_cmp++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_valid: got %b want 0", dv[0]); end
    n_cmp++; if (dd[0] !== vals[2]) begin n_fail++; $display("FAIL b2b_empty_holds_last: got %h want %h", dd[0], vals[2]); end
  endtask

  task automatic test_skid_full();
    do_reset();
    stage_ready_go = 1'b1;
    dn_allow_in    = 1'b0;
    up_valid       = 1'b1;
    up_data        = 32'h0000_0201;
    #2;
    n_cmp++; if (al[1] !== 1'b1) begin n_fail++; $display("FAIL full_allow0: got %b want 1", al[1]); end
    tick();
    up_data = 32'h0000_0202;
    #2;
    n_cmp++; if (c2 !== 2'd1) begin n_fail++; $display("FAIL full_count1: got %0d want 1", c2); end
    tick();
    up_data = 32'h0000_0203;
    #2;
    n_cmp++; if (c2 !== 2'd2) begin n_fail++; $display("FAIL full_count2: got %0d want 2", c2); end
    n_cmp++; if (al[1] !== 1'b0) begin n_fail++; $display("FAIL full_allow_blocked: got %b want 0", al[1]); end
    dn_allow_in = 1'b1;
    #1;
    n_cmp++; if (al[1] !== 1'b0) begin n_fail++; $display("FAIL full_allow_no_dn_path: got %b want 0", al[1]); end
    n_cmp++; if (dd[1] !== 32'h0000_0201) begin n_fail++; $display("FAIL full_head1: got %h want 00000201", dd[1]); end
    tick();
    #2;
    n_cmp++; if (c2 !== 2'd1) begin n_fail++; $display("FAIL drain_count_a: got %0d want 1", c2); end
    n_cmp++; if (al[1] !== 1'b1) begin n_fail++; $display("FAIL drain_allow: got %b want 1", al[1]); end
    n_cmp++; if (dd[1] !== 32'h0000_0202) begin n_fail++; $display("FAIL drain_head2: got %h want 00000202", dd[1]); end
    tick();
    up_valid = 1'b0;
    #2;
    n_cmp++; if (c2 !== 2'd1) begin n_fail++; $display("FAIL drain_count_b: got %0d want 1", c2); end
    n_cmp++; if (dd[1] !== 32'h0000_0203) begin n_fail++; $display("FAIL drain_head3: got %h want 00000203", dd[1]); end
    tick();
    #2;
    n_cmp++; if (c2 !== 2'd0) begin n_fail++; $display("FAIL drain_count_end: got %0d want 0", c2); end
    n_cmp++; if (dv[1] !== 1'b0) begin n_fail++; $display("FAIL drain_valid_end: got %b want 0", dv[1]); end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int popped = 0;
    do_reset();
    stage_ready_go = 1'b1;
    for (int cyc = 0; cyc < 80 && popped < 7; cyc++) begin
      up_valid    = (pushed < 7);
      up_data     = 32'h300 + pushed;
      dn_allow_in = ($urandom_range(0, 2) != 0);
      #2;
      n_cmp++; if (c3 !== 2'(pushed - popped)) begin n_fail++; $display("FAIL wrap_count cycle %0d: got %0d want %0d", cyc, c3, pushed - popped); end
      if (dv[2] && dn_allow_in) begin
        n_cmp++; if (dd[2] !== 32'h300 + popped) begin n_fail++; $display("FAIL wrap_order item %0d: got %h want %h", popped, dd[2], 32'h300 + popped); end
        popped++;
      end
      if (up_valid && al[2]) pushed++;
      tick();
    end
    n_cmp++; if (popped != 7) begin n_fail++; $display("FAIL wrap_timeout: got %0d popped want 7", popped); end
  endtask

  task automatic test_flush();
    do_reset();
    stage_ready_go = 1'b1;
    dn_allow_in    = 1'b0;
    up_valid       = 1'b1;
    up_data        = 32'h0000_0F01;
    tick();
    up_data = 32'h0000_0F02;
    tick();
    up_data = 32'hDEAD_BEEF;
    flush   = 1'b1;
    #2;
    n_cmp++; if (c3 !== 2'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 2", c3); end
    tick();
    up_valid = 1'b0;
    flush    = 1'b0;
    #2;
    n_cmp++; if (c3 !== 2'd0) begin n_fail++; $display("FAIL flush_count_d3: got %0d want 0", c3); end
    n_cmp++; if (c2 !== 2'd0) begin n_fail++; $display("FAIL flush_count_d2: got %0d want 0", c2); end
    n_cmp++; if (c1 !== 1'd0) begin n_fail++; $display("FAIL flush_count_d1: got %0d want 0", c1); end
    n_cmp++; if (dv[2] !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", dv[2]); end
    dn_allow_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (dv[2] !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost cycle %0d: got %b want 0", i, dv[2]); end
      tick();
    end
    up_valid = 1'b1;
    up_data  = 32'h0000_0A5A;
    tick();
    up_valid = 1'b0;
    #2;
    n_cmp++; if (dv[2] !== 1'b1) begin n_fail++; $display("FAIL flush_refill_valid: got %b want 1", dv[2]); end
    n_cmp++; if (dd[2] !== 32'h0000_0A5A) begin n_fail++; $display("FAIL flush_refill_data: got %h want 00000a5a", dd[2]); end
    n_cmp++; if (c3 !== 2'd1) begin n_fail++; $display("FAIL flush_refill_count: got %0d want 1", c3); end
  endtask

  task automatic test_stall();
    do_reset();
    stage_ready_go = 1'b1;
    dn_allow_in    = 1'b0;
    up_valid       = 1'b1;
    up_data        = 32'h0000_5001;
    tick();
    dn_allow_in    = 1'b1;
    stage_ready_go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_valid = (i == 1);
      up_data  = 32'h0000_5002;
      #2;
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (dv[k] !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d] cycle %0d: got %b want 0", k, i, dv[k]); end
      end
      n_cmp++; if (c1 !== 1'd1) begin n_fail++; $display("FAIL stall_hold_d1 cycle %0d: got %0d want 1", i, c1); end
      n_cmp++; if (al[0] !== 1'b0) begin n_fail++; $display("FAIL stall_allow_d1 cycle %0d: got %b want 0", i, al[0]); end
      n_cmp++; if (c3 !== ((i < 2) ? 2'd1 : 2'd2)) begin n_fail++; $display("FAIL stall_fill_d3 cycle %0d: got %0d want %0d", i, c3, (i < 2) ? 1 : 2); end
      tick();
    end
    up_valid       = 1'b0;
    stage_ready_go = 1'b1;
    #2;
    n_cmp++; if (dv[0] !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid: got %b want 1", dv[0]); end
    n_cmp++; if (dd[0] !== 32'h0000_5001) begin n_fail++; $display("FAIL stall_release_data: got %h want 00005001", dd[0]); end
    n_cmp++; if (dd[2] !== 32'h0000_5001) begin n_fail++; $display("FAIL stall_release_d3: got %h want 00005001", dd[2]); end
    tick();
    #2;
    n_cmp++; if (c1 !== 1'd0) begin n_fail++; $display("FAIL stall_popped_d1: got %0d want 0", c1); end
    n_cmp++; if (dd[2] !== 32'h0000_5002) begin n_fail++; $display("FAIL stall_next_d3: got %h want 00005002", dd[2]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stage_ready_go = 1'b1;
    dn_allow_in    = 1'b0;
    up_valid       = 1'b1;
    up_data        = $urandom;
    tick();
    up_data = $urandom;
    tick();
    idle_inputs();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (dut_count(k) !== 3'd0) begin n_fail++; $display("FAIL midrst_count[%0d]: got %0d want 0", k, dut_count(k)); end
      n_cmp++; if (dd[k] !== RV) begin n_fail++; $display("FAIL midrst_dn_data[%0d]: got %h want %h", k, dd[k], RV); end
      n_cmp++; if (al[k] !== 1'b1) begin n_fail++; $display("FAIL midrst_allow[%0d]: got %b want 1", k, al[k]); end
    end
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      up_valid       = ($urandom_range(0, 9) < 7);
      up_data        = $urandom;
      flush          = ($urandom_range(0, 11) == 0);
      stage_ready_go = ($urandom_range(0, 4) != 0);
      dn_allow_in    = ($urandom_range(0, 9) < 6);
      #2;
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (dv[k] !== exp_dv(k)) begin n_fail++; $display("FAIL rand_dn_valid[%0d] cycle %0d: got %b want %b", k, cyc, dv[k], exp_dv(k)); end
        n_cmp++; if (al[k] !== exp_allow(k)) begin n_fail++; $display("FAIL rand_allow[%0d] cycle %0d: got %b want %b", k, cyc, al[k], exp_allow(k)); end
        n_cmp++; if (dut_count(k) !== 3'(m_cnt[k])) begin n_fail++; $display("FAIL rand_count[%0d] cycle %0d: got %0d want %0d", k, cyc, dut_count(k), m_cnt[k]); end
        if (m_cnt[k] != 0) begin
          n_cmp++; if (dd[k] !== m_list[k][0]) begin n_fail++; $display("FAIL rand_head[%0d] cycle %0d: got %h want %h", k, cyc, dd[k], m_list[k][0]); end
        end else if (k == 0) begin
          n_cmp++; if (dd[0] !== m_last1) begin n_fail++; $display("FAIL rand_idle_d1 cycle %0d: got %h want %h", cyc, dd[0], m_last1); end
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_back_to_back();
    test_skid_full();
    test_wrap();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
